// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - EX-stage sequencer for the shared multiplier/divider with HI/LO write-back
module mdu_ctrl #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_kind,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    // Counter only has to reach MUL_LAT-1; keep at least one bit for MUL_LAT==1.
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    localparam logic [1:0] K_MULT  = 2'b00;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL      = 2'b01,
        DIV_WAIT = 2'b10,
        DONE     = 2'b11
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          neg;
    logic          accept;
    logic          mul_last;
    logic          div_hit;
    logic [63:0]   mul_fixed;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude for the unsigned multiplier.
    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign accept   = (state == IDLE) && op_valid && !flush;
    assign mul_last = (state == MUL) && (cnt == CNT_LAST);
    // The cycle carrying div_start is excluded: a level-style ready left over
    // from a previous division must not be taken as this op's result.
    assign div_hit  = (state == DIV_WAIT) && div_ready && !div_start;
    assign mul_fixed = neg ? (~mul_p + 64'd1) : mul_p;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, stall and HI/LO write strobe; flush overrides everything.
    always_comb begin
        state_n = state;
        stall   = 1'b0;
        hilo_we = 1'b0;
        case (state)
            IDLE: begin
                stall = op_valid;
                if (accept) begin
                    state_n = op_kind[1] ? DIV_WAIT : MUL;
                end
            end
            MUL: begin
                stall = 1'b1;
                if (mul_last) begin
                    state_n = DONE;
                end
            end
            DIV_WAIT: begin
                stall = 1'b1;
                if (div_hit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                hilo_we = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            stall   = 1'b0;
            hilo_we = 1'b0;
        end
    end

    // MUL cycle counter, restarted on accept and on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush || accept) begin
            cnt <= '0;
        end else if (state == MUL) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Operand latches; each unit's operands only change when an op for it is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            neg        <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_signed <= 1'b0;
        end else if (accept) begin
            if (op_kind[1]) begin
                div_a      <= op_a;
                div_b      <= op_b;
                div_signed <= ~op_kind[0];
            end else if (op_kind == K_MULT) begin
                mul_a <= mag(op_a);
                mul_b <= mag(op_b);
                neg   <= op_a[31] ^ op_b[31];
            end else begin
                mul_a <= op_a;
                mul_b <= op_b;
                neg   <= 1'b0;
            end
        end
    end

    // Divider start pulse follows a divide accept; annul follows a flush of an in-flight divide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_start <= 1'b0;
            div_annul <= 1'b0;
        end else begin
            div_start <= accept && op_kind[1];
            div_annul <= flush && (state == DIV_WAIT);
        end
    end

    // HI/LO capture on the last MUL cycle or on divider ready; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (!flush) begin
            if (mul_last) begin
                {hi_out, lo_out} <= mul_fixed;
            end else if (div_hit) begin
                {hi_out, lo_out} <= div_result;
            end
        end
    end

endmodule
